unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares one single-port synchronous unified memory between the core's instruction-fetch port and its data port.
- Sits between the single-cycle/multicycle core and the unified memory, replacing separate instruction and data memories.
- Arbitrates between the two ports, sequences each access through the fixed memory read latency, and returns one response per accepted request.
- At most one transaction is outstanding at a time.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MEM_LAT, 1, memory read latency in cycles; legal range 1..4, any other value is an elaboration error
- DATA_PRIORITY, 1, 1 = data port has fixed priority; 0 = round-robin

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  ADDR_W  fetch address
- if_rsp_valid  out  1  fetch data valid
- if_rdata  out  DATA_W  fetch data
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_we  in  1  1 = write
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_be  in  DATA_W/8  byte enables
- d_rsp_valid  out  1  read data valid, or write acknowledge
- d_rdata  out  DATA_W  read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_be  out  DATA_W/8  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the accept edge
- busy  out  1  transaction outstanding

Behaviour:
- Reset state:
  - FSM in IDLE; cnt = 0; last_grant = D, so round-robin grants IF first.
  - All outputs are 0 while reset is low, including both ready signals.
- FSM states: IDLE, WAIT.
- IDLE:
  - Grant is combinational from the two request valids.
  - DATA_PRIORITY=1: data port wins any conflict.
  - DATA_PRIORITY=0: the port not granted last wins.
  - Exactly one x_req_ready is high, only in the granted port's cycle, so handshake = valid & ready.
  - In the accept cycle T, mem_en=1 and the mem_* outputs are driven combinationally from the granted port:
    - fetch: mem_we=0, mem_be all ones;
    - data: mem_we = d_we, mem_be = d_be, mem_wdata = d_wdata.
  - On accept, the FSM registers owner and direction, loads cnt = MEM_LAT-1, and moves to WAIT.
  - No valid request: mem_en=0; all mem_* outputs are 0.
- WAIT:
  - Both ready signals are 0, mem_en=0, busy=1.
  - cnt decrements each cycle while nonzero.
  - When cnt==0, the owner's rsp_valid is 1 for exactly that cycle, and the FSM returns to IDLE.
- Response timing: the response cycle is T+MEM_LAT; the next accept is possible at T+MEM_LAT+1.
- Response data:
  - Read: owner rdata = mem_rdata, passed through combinationally.
  - Write: d_rsp_valid acts as the write acknowledge, with d_rdata = 0.
  - The non-owner's rdata is always 0; rdata is 0 whenever rsp_valid is 0.
- Requester rules:
  - A requester holds valid and its request fields stable until ready.
  - A requester may drop valid before it is granted; no transaction results.
- Starvation: with DATA_PRIORITY=1, a continuously valid data port starves fetch. This is accepted, because the core cannot issue back-to-back data requests without fetching.
- Reset mid-transaction: the FSM returns to IDLE immediately, the pending response is discarded (no rsp_valid), and the memory write side effect of an already accepted write is not undone.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, WAIT);
  - owner enum (OWN_IF, OWN_D);
  - MEM_LAT_MIN = 1 and MEM_LAT_MAX = 4.
- Sub-module arb2: 2-request arbiter with a priority-mode parameter, its own last_grant register, and an update-on-accept input.

Test Plan:
1. MEM_LAT=1, fetch-only read:
   - Stimulus: if_addr=0x10, memory returns 0x00500113.
   - Required: at T, mem_en=1, mem_addr=0x10, mem_be=0xF. At T+1, if_rsp_valid=1, if_rdata=0x00500113, if_req_ready=0.
2. Data write:
   - Stimulus: d_addr=0x64, d_wdata=0x19, d_be=0xF.
   - Required: at T, mem_we=1 with those values. At T+1, d_rsp_valid=1 and d_rdata=0; if_rsp_valid stays 0.
3. DATA_PRIORITY=1, both ports valid at T:
   - Required: data accepted at T. Fetch accepted at T+2 with if_rsp_valid at T+3.
4. DATA_PRIORITY=0, MEM_LAT=1, both ports held valid for 8 cycles:
   - Required: accepts at T, T+2, T+4, T+6, ordered IF, D, IF, D.
5. MEM_LAT=3, read accepted at T:
   - Required: both ready signals 0 and busy=1 for T+1..T+3. rsp_valid only at T+3. Next accept at T+4.
6. Read accepted at T, reset pulled low at T+1 and released at T+3:
   - Required: no rsp_valid, and all outputs 0 during reset. A request pending after release is accepted in the first clock after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the unified memory arbiter.
//   state_t : transaction FSM states
//   owner_t : which core port owns the outstanding transaction
package mem_arb_pkg;

    localparam int unsigned MEM_LAT_MIN = 1;
    localparam int unsigned MEM_LAT_MAX = 4;
    // Down-counter width, enough for MEM_LAT_MAX-1
    localparam int unsigned CNT_W       = 2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the core (fetch + data ports), the arbiter and the memory.
//   slave  : arbiter side
//   master : core / memory side (drives requests and mem_rdata)
interface unified_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req_valid;
    logic              d_req_ready;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req_valid, if_addr,
        output if_req_ready, if_rsp_valid, if_rdata,
        input  d_req_valid, d_we, d_addr, d_wdata, d_be,
        output d_req_ready, d_rsp_valid, d_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output if_req_valid, if_addr,
        input  if_req_ready, if_rsp_valid, if_rdata,
        output d_req_valid, d_we, d_addr, d_wdata, d_be,
        input  d_req_ready, d_rsp_valid, d_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/arb2.sv
// Two-request arbiter (fetch vs data).
//   PRIO_D=1 : data always wins a conflict; PRIO_D=0 : round-robin
//   i_accept : a grant was taken this cycle, remember who got it
//   o_gnt_*_c: combinational one-hot grant
module arb2 #(
    parameter bit PRIO_D = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req_if,
    input  logic i_req_d,
    input  logic i_accept,
    output logic o_gnt_if_c,
    output logic o_gnt_d_c
);

    // 1 = data port got the last grant; reset value makes fetch win first
    logic r_last_d;

    // Grant decode
    always_comb begin
        o_gnt_if_c = 1'b0;
        o_gnt_d_c  = 1'b0;
        if (i_req_if && i_req_d) begin
            if (PRIO_D || !r_last_d) o_gnt_d_c  = 1'b1;
            else                     o_gnt_if_c = 1'b1;
        end else begin
            o_gnt_if_c = i_req_if;
            o_gnt_d_c  = i_req_d;
        end
    end

    // Last-grant history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_last_d <= 1'b1;
        else if (i_accept) r_last_d <= o_gnt_d_c;
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous memory between the fetch and data ports.
// One transaction outstanding at a time; response MEM_LAT cycles after accept.
//   clk, reset : clock, async active-low reset
//   bus        : fetch/data request+response ports, memory port, busy
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MEM_LAT       = 1,
    parameter int unsigned DATA_PRIORITY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    unified_mem_arbiter_if.slave   bus
);

    localparam int unsigned BE_W = DATA_W / 8;

    if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
        $error("unified_mem_arbiter: MEM_LAT must be 1..4");
    end

    state_t           r_state;
    owner_t           r_owner;
    logic             r_we;
    logic [CNT_W-1:0] r_cnt;

    logic w_idle;
    logic w_gnt_if;
    logic w_gnt_d;
    logic w_accept;
    logic w_rsp;

    // Grants only exist in IDLE and out of reset, so readies read 0 during reset
    assign w_idle   = (r_state == IDLE) && reset;
    assign w_accept = w_idle && (w_gnt_if || w_gnt_d);
    assign w_rsp    = (r_state == WAIT) && (r_cnt == '0);

    arb2 #(
        .PRIO_D (DATA_PRIORITY != 0)
    ) u_arb2 (
        .clk        (clk),
        .reset      (reset),
        .i_req_if   (bus.if_req_valid),
        .i_req_d    (bus.d_req_valid),
        .i_accept   (w_accept),
        .o_gnt_if_c (w_gnt_if),
        .o_gnt_d_c  (w_gnt_d)
    );

    assign bus.if_req_ready = w_idle && w_gnt_if;
    assign bus.d_req_ready  = w_idle && w_gnt_d;

    // Memory port driven straight from the granted request in the accept cycle
    always_comb begin
        bus.mem_en    = w_accept;
        bus.mem_we    = 1'b0;
        bus.mem_be    = BE_W'(0);
        bus.mem_addr  = ADDR_W'(0);
        bus.mem_wdata = DATA_W'(0);
        if (w_idle && w_gnt_d) begin
            bus.mem_we    = bus.d_we;
            bus.mem_be    = bus.d_be;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end else if (w_idle && w_gnt_if) begin
            bus.mem_be    = '1;
            bus.mem_addr  = bus.if_addr;
        end
    end

    // Responses: read data passes through only for the owner's read
    assign bus.if_rsp_valid = w_rsp && (r_owner == OWN_IF);
    assign bus.d_rsp_valid  = w_rsp && (r_owner == OWN_D);
    assign bus.if_rdata     = bus.if_rsp_valid ? bus.mem_rdata : DATA_W'(0);
    assign bus.d_rdata      = (bus.d_rsp_valid && !r_we) ? bus.mem_rdata : DATA_W'(0);
    assign bus.busy         = (r_state == WAIT);

    // Transaction FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_owner <= OWN_IF;
            r_we    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_gnt_d ? OWN_D : OWN_IF;
                        r_we    <= w_gnt_d && bus.d_we;
                        r_cnt   <= CNT_W'(MEM_LAT - 1);
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) r_state <= IDLE;
                    else             r_cnt   <= r_cnt - CNT_W'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
